comb_job_arbiter: RTL and testbench

- Shares one Combination engine (start/n/m in; done/out_put back) among NUM_REQ requesters, each asking for C(n,m).
- Round-robin selection, one job in flight at a time.
- Latches operands, pulses engine start, waits for done, captures the 13-bit result and returns it with a per-requester ack pulse.
- Sits between the requesting blocks and the engine instance.

---
 rtl/comb_job_arbiter.sv | 144 ++++++++++++++
 tb/tb_comb_job_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/comb_job_arbiter.sv
// Round-robin front end that shares one C(n,m) engine among NUM_REQ requesters, one job at a time.
// Define COMB_TRIVIAL_BYPASS_EN to answer m>n, m==0, m==n and m==1 locally without the engine.
module comb_job_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   req_n,
    input  logic [4*NUM_REQ-1:0]   req_m,
    output logic [NUM_REQ-1:0]     ack,
    output logic [12:0]            result,
    output logic [ID_W-1:0]        result_id,
    output logic                   busy,
    output logic                   eng_start,
    output logic [3:0]             eng_n,
    output logic [3:0]             eng_m,
    input  logic                   eng_done,
    input  logic [12:0]            eng_result
);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, REPLY} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    logic [ID_W-1:0] result_id_q, result_id_d;
    logic [3:0]      eng_n_q, eng_n_d;
    logic [3:0]      eng_m_q, eng_m_d;
    logic [12:0]     result_q, result_d;
    logic            done_q;

    logic            found;
    logic [ID_W-1:0] pick;
    logic [3:0]      pick_n;
    logic [3:0]      pick_m;

`ifdef COMB_TRIVIAL_BYPASS_EN
    function automatic logic is_trivial(input logic [3:0] n, input logic [3:0] m);
        return (m > n) || (m == 4'd0) || (m == n) || (m == 4'd1);
    endfunction

    function automatic logic [12:0] trivial_result(input logic [3:0] n, input logic [3:0] m);
        if (m > n)
            return 13'd0;
        if ((m == 4'd0) || (m == n))
            return 13'd1;
        return {9'd0, n};
    endfunction
`endif

    // Scan starts just after the last winner, so the last winner has lowest priority.
    always_comb begin
        logic [ID_W-1:0] cand;
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        pick_n = req_n[4*pick +: 4];
        pick_m = req_m[4*pick +: 4];
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_id_d    = gnt_id_q;
        eng_n_d     = eng_n_q;
        eng_m_d     = eng_m_q;
        result_d    = result_q;
        result_id_d = result_id_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    rr_ptr_d = pick;
                    gnt_id_d = pick;
                    eng_n_d  = pick_n;
                    eng_m_d  = pick_m;
                    state_d  = LAUNCH;
`ifdef COMB_TRIVIAL_BYPASS_EN
                    if (is_trivial(pick_n, pick_m)) begin
                        result_d    = trivial_result(pick_n, pick_m);
                        result_id_d = pick;
                        state_d     = REPLY;
                    end
`endif
                end
            end
            LAUNCH: state_d = RUN;
            RUN: begin
                // Only a fresh rising edge counts; a done level left from the previous job is stale.
                if (eng_done && !done_q) begin
                    result_d    = eng_result;
                    result_id_d = gnt_id_q;
                    state_d     = REPLY;
                end
            end
            REPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack = '0;
        if (state_q == REPLY)
            ack[gnt_id_q] = 1'b1;
    end

    assign busy      = (state_q != IDLE);
    assign eng_start = (state_q == LAUNCH);
    assign eng_n     = eng_n_q;
    assign eng_m     = eng_m_q;
    assign result    = result_q;
    assign result_id = result_id_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= ID_W'(NUM_REQ - 1);
            gnt_id_q    <= '0;
            eng_n_q     <= '0;
            eng_m_q     <= '0;
            result_q    <= '0;
            result_id_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_id_q    <= gnt_id_d;
            eng_n_q     <= eng_n_d;
            eng_m_q     <= eng_m_d;
            result_q    <= result_d;
            result_id_q <= result_id_d;
            done_q      <= eng_done;
        end
    end

endmodule

// File: tb/tb_comb_job_arbiter.sv
// Randomized bench for comb_job_arbiter with a behavioural engine and a job-level reference model.
module tb_comb_job_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req;
    logic [4*NUM_REQ-1:0] req_n;
    logic [4*NUM_REQ-1:0] req_m;
    logic [NUM_REQ-1:0]   ack;
    logic [12:0]          result;
    logic [ID_W-1:0]      result_id;
    logic                 busy;
    logic                 eng_start;
    logic [3:0]           eng_n;
    logic [3:0]           eng_m;
    logic                 eng_done;
    logic [12:0]          eng_result;

    comb_job_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_n(req_n), .req_m(req_m),
        .ack(ack), .result(result), .result_id(result_id), .busy(busy),
        .eng_start(eng_start), .eng_n(eng_n), .eng_m(eng_m),
        .eng_done(eng_done), .eng_result(eng_result)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // job-level reference model
    bit m_busy;
    int job_id, job_n, job_m, job_res, last_id;
    int grant_cyc, exp_start_cyc, exp_ack_cyc, m_free_cyc;
    int served_q[$];
    // engine model
    bit e_active;
    int e_t, e_hold, e_lat, e_res, extra_lat;
    // requester behaviour
    bit auto_en;
    int raise_pct, perturb_pct;
    logic [NUM_REQ-1:0] last_ack;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int binom(input int n, input int m);
        int r;
        if (m > n) return 0;
        r = 1;
        for (int k = 1; k <= m; k++) r = r * (n - k + 1) / k;
        return r;
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
        for (int k = 1; k <= NUM_REQ; k++)
            if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic decide();
        if (!m_busy && cyc >= m_free_cyc && req != '0) begin
            job_id        = rr_pick(req, last_id);
            job_n         = int'(req_n[4*job_id +: 4]);
            job_m         = int'(req_m[4*job_id +: 4]);
            job_res       = binom(job_n, job_m);
            last_id       = job_id;
            m_busy        = 1'b1;
            grant_cyc     = cyc;
            exp_start_cyc = cyc + 1;
            exp_ack_cyc   = -1;
`ifdef COMB_TRIVIAL_BYPASS_EN
            if (job_m > job_n || job_m == 0 || job_m == job_n || job_m == 1) begin
                exp_start_cyc = -1;
                exp_ack_cyc   = cyc + 1;
            end
`endif
        end
    endtask

    task automatic drop_done();
        eng_done   = 1'b0;
        eng_result = 13'($urandom);
    endtask

    task automatic step();
        logic [NUM_REQ-1:0] exp_ack;
        @(negedge clk);
        cyc++;
        exp_ack = '0;
        if (m_busy && cyc == exp_ack_cyc) exp_ack[job_id] = 1'b1;
        chk("ack", ack, exp_ack);
        chk("busy", busy, m_busy);
        chk("eng_start", eng_start, (m_busy && cyc == exp_start_cyc));
        if (m_busy && cyc > grant_cyc) begin
            chk("eng_n", eng_n, job_n);
            chk("eng_m", eng_m, job_m);
        end
        if (m_busy && cyc == exp_ack_cyc) begin
            chk("result", result, job_res);
            chk("result_id", result_id, job_id);
            served_q.push_back(job_id);
            m_busy     = 1'b0;
            m_free_cyc = cyc + 1;
        end else if (m_busy && cyc == grant_cyc + 40) begin
            chk("job_timeout", 0, 1);
            m_busy     = 1'b0;
            m_free_cyc = cyc + 1;
        end
        last_ack = ack;

        if (eng_start) begin
            e_active = 1'b1;
            e_t      = 0;
            e_hold   = $urandom_range(0, 2);
            e_lat    = e_hold + $urandom_range(1, 5) + extra_lat;
            e_res    = binom(int'(eng_n), int'(eng_m));
            if (e_hold == 0) drop_done();
        end else if (e_active) begin
            e_t++;
            if (e_t == e_hold) drop_done();
            if (e_t == e_lat) begin
                eng_done   = 1'b1;
                eng_result = 13'(e_res);
                e_active   = 1'b0;
                if (m_busy) exp_ack_cyc = cyc + 1;
            end
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            if (ack[i]) begin
                req[i] = 1'b0;
            end else if (auto_en && !req[i] && $urandom_range(0, 99) < raise_pct) begin
                req_n[4*i +: 4] = 4'($urandom);
                req_m[4*i +: 4] = 4'($urandom);
                req[i] = 1'b1;
            end else if (m_busy && i == job_id && cyc > grant_cyc && req[i] &&
                         $urandom_range(0, 99) < perturb_pct) begin
                if ($urandom_range(0, 1) == 1) begin
                    req[i] = 1'b0;
                end else begin
                    req_n[4*i +: 4] = 4'($urandom);
                    req_m[4*i +: 4] = 4'($urandom);
                end
            end
        end
        decide();
    endtask

    task automatic issue(input int i, input int n, input int m);
        req_n[4*i +: 4] = 4'(n);
        req_m[4*i +: 4] = 4'(m);
        req[i] = 1'b1;
        decide();
    endtask

    task automatic wait_ack(input int i);
        for (int k = 0; k < 100; k++) begin
            step();
            if (last_ack[i]) break;
        end
        chk("ack_seen", last_ack[i], 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 400; k++) begin
            if (!m_busy && req == '0) break;
            step();
        end
        chk("drain_idle", {m_busy, (req != '0)}, 0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_ack"}, ack, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_eng_start"}, eng_start, 0);
        chk({pfx, "_result"}, result, 0);
        chk({pfx, "_result_id"}, result_id, 0);
        chk({pfx, "_eng_n"}, eng_n, 0);
        chk({pfx, "_eng_m"}, eng_m, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        rst        = 1'b1;
        req        = '1;
        req_n      = 16'($urandom);
        req_m      = 16'($urandom);
        eng_done   = 1'b0;
        eng_result = '0;
        m_busy     = 1'b0;
        last_id    = NUM_REQ - 1;
        m_free_cyc = 0;
        e_active   = 1'b0;
        extra_lat  = 0;
        auto_en    = 1'b1;
        raise_pct  = 100;
        perturb_pct = 0;
        last_ack   = '0;

        @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        decide();

        // all four held from reset and re-raised after each ack
        for (int k = 0; k < 200 && served_q.size() < 5; k++) step();
        if (served_q.size() < 5)
            chk("rr_count", served_q.size(), 5);
        else
            for (int k = 0; k < 5; k++) chk("rr_order", served_q[k], exp_order[k]);
        auto_en = 1'b0;
        drain();

        issue(1, 5, 2);
        wait_ack(1);
        chk("c5_2", result, 10);
        chk("c5_2_id", result_id, 1);

        issue(3, 12, 6);
        wait_ack(3);
        chk("c12_6", result, 924);
        chk("c12_6_id", result_id, 3);

        extra_lat = 3;
        issue(2, 7, 3);
        for (int k = 0; k < 20 && !(m_busy && cyc >= exp_start_cyc + 1); k++) step();
        req[2] = 1'b0;
        wait_ack(2);
        chk("c7_3_dropped", result, 35);

        extra_lat = 6;
        issue(0, 9, 4);
        for (int k = 0; k < 20 && !(m_busy && cyc >= exp_start_cyc + 2); k++) step();
        #1 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        m_busy     = 1'b0;
        m_free_cyc = 0;
        last_id    = NUM_REQ - 1;
        e_active   = 1'b0;
        eng_done   = 1'b0;
        req        = '0;
        step();
        step();
        rst       = 1'b0;
        extra_lat = 0;
        issue(0, 9, 4);
        wait_ack(0);
        chk("c9_4_after_rst", result, 126);

        auto_en     = 1'b1;
        raise_pct   = 25;
        perturb_pct = 15;
        for (int k = 0; k < 3000; k++) step();
        auto_en     = 1'b0;
        perturb_pct = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
